encoder_8to3_drain: RTL and testbench
=====================================

ENCODER_8TO3_DRAIN -- requirements
Module: encoder_8to3_drain

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 enable  input  1  block enable; low blocks capture and freezes draining.
REQ-004 in_valid  input  1  vector d present this cycle.
REQ-005 in_ready  output  1  block accepts d this cycle.
REQ-006 d  input  8  multi-hot request vector; bit 7 highest priority.
REQ-007 out_valid  output  1  encoded index a valid this cycle.
REQ-008 out_ready  input  1  consumer accepts a this cycle.
REQ-009 a  output  3  binary index of highest pending set bit.
REQ-010 last  output  1  current beat is the final index of the captured vector.
REQ-011 count  output  4  number of pending set bits, range 0..8.
REQ-012 zero  output  1  one-cycle pulse: captured vector was all zeros.

Function
REQ-013 The block SHALL implement two states, IDLE and DRAIN, plus an 8-bit pending register pend.
REQ-014 in_ready SHALL equal (state==IDLE) & enable, combinationally.
REQ-015 Capture SHALL occur on a rising edge with in_valid & in_ready; pend <= d.
REQ-016 On capture with d != 0, state SHALL go to DRAIN; out_valid SHALL be high in the next cycle (1-cycle latency).
REQ-017 On capture with d == 0, state SHALL remain IDLE, zero SHALL be 1 for exactly the next cycle, and no out_valid beat SHALL occur.
REQ-018 out_valid SHALL equal (state==DRAIN) & enable.
REQ-019 a SHALL be the index of the highest set bit of pend while out_valid=1, else 3'd0.
REQ-020 count SHALL equal the popcount of pend at all times (4-bit, max 8, no overflow).
REQ-021 last SHALL be 1 iff out_valid=1 and count==1; else 0.
REQ-022 On out_valid & out_ready, the bit of pend at index a SHALL be cleared at that edge; next beat presents the next-lower set bit.
REQ-023 On out_valid & out_ready with last=1, state SHALL return to IDLE; in_ready may rise the next cycle (no back-to-back capture in the same cycle).
REQ-024 With out_valid=1 and out_ready=0, a, last, count SHALL hold stable.
REQ-025 enable=0 in DRAIN SHALL freeze pend and state; out_valid low; draining resumes unchanged when enable returns to 1.
REQ-026 in_valid during DRAIN SHALL be ignored (in_ready=0); d is not sampled.
REQ-027 An N-bit-set vector with out_ready held 1 SHALL drain in exactly N consecutive cycles, highest index first.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, pend=0, zero=0, regardless of clk.
REQ-029 While/after reset: out_valid=0, a=0, last=0, count=0, zero=0, in_ready=enable.
REQ-030 Reset asserted mid-DRAIN SHALL discard all pending bits; no further beats after release until a new capture.

Verification
REQ-031 enable=1, out_ready=1, capture d=8'b1010_0101 -> a=7,5,2,0 on 4 consecutive cycles, count=4,3,2,1, last only on a=0, then in_ready=1.
REQ-032 Sweep i=0..7 with d=(1<<i), enable=0 first (in_ready=0, no output) then enable=1 -> each gives single beat a=i, last=1, count=1.
REQ-033 Capture d=8'h00 -> zero=1 for one cycle, out_valid stays 0, in_ready remains 1.
REQ-034 Capture d=8'h30, out_ready=0 for 3 cycles -> a=5, count=2 held stable; then out_ready=1 -> a=5 then a=4 with last=1.
REQ-035 Capture d=8'hFF, enable=0 after 2 beats for 4 cycles -> out_valid=0, count=6 held; enable=1 -> resumes a=5..0.
REQ-036 Capture d=8'hC3, rst_n=0 after first beat -> out_valid=0, count=0 immediately; after release no beats until new capture.

Source files
------------

// File: rtl/encoder_8to3_drain.sv
// Captures a multi-hot vector and drains its set bits highest-first, one index per out_ready beat.
// First beat one cycle after capture; out_ready low holds the beat, enable low freezes capture and drain.
module encoder_8to3_drain (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] d,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] a,
   output logic       last,
   output logic [3:0] count,
   output logic       zero
);

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_pend;
   logic       r_zero;
   logic       w_capture;
   logic       w_take;
   logic [2:0] w_idx;
   logic [3:0] w_cnt;

   // Later iterations overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      w_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (r_pend[i]) w_idx = 3'(i);
      end
   end

   always_comb begin
      w_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_cnt = w_cnt + {3'd0, r_pend[i]};
      end
   end

   assign w_capture = in_valid & in_ready;
   assign w_take    = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_capture && (d != 8'd0)) w_state_nxt = DRAIN;
         DRAIN:   if (w_take && last)           w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE) & enable;
      out_valid = (r_state == DRAIN) & enable;
      a         = out_valid ? w_idx : 3'd0;
      count     = w_cnt;
      last      = out_valid & (w_cnt == 4'd1);
      zero      = r_zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= 8'd0;
         r_zero <= 1'b0;
      end else begin
         r_zero <= w_capture & (d == 8'd0);
         if (w_capture)   r_pend <= d;
         else if (w_take) r_pend <= r_pend & ~(8'd1 << w_idx);
      end
   end

endmodule

// File: tb/tb_encoder_8to3_drain.sv
// Directed and randomized checks of encoder_8to3_drain against a queue-of-indices reference model.
module tb_encoder_8to3_drain;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] d = 8'd0;
   logic       in_ready;
   logic       out_valid;
   logic       last;
   logic       zero;
   logic [2:0] a;
   logic [3:0] count;

   int total = 0;
   int bad   = 0;

   // Model: pending indices in drain order (highest first); busy iff non-empty.
   int q[$];
   bit m_zero = 1'b0;

   always #5 clk = ~clk;

   encoder_8to3_drain dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a         (a),
      .last      (last),
      .count     (count),
      .zero      (zero)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_outputs(output bit e_ir, output bit e_ov);
      bit busy;
      busy = (q.size() != 0);
      e_ir = !busy && enable;
      e_ov = busy && enable;
      chk("in_ready", {7'd0, in_ready}, {7'd0, e_ir});
      chk("out_valid", {7'd0, out_valid}, {7'd0, e_ov});
      chk("a", {5'd0, a}, e_ov ? 8'(q[0]) : 8'd0);
      chk("count", {4'd0, count}, 8'(q.size()));
      chk("last", {7'd0, last}, {7'd0, (e_ov && q.size() == 1)});
      chk("zero", {7'd0, zero}, {7'd0, m_zero});
   endtask

   // Entered and left at posedge+1; checks mid-cycle, then advances the model across the edge.
   task automatic cyc(input bit en, input bit iv, input logic [7:0] dd, input bit ordy);
      bit e_ir;
      bit e_ov;
      enable    = en;
      in_valid  = iv;
      d         = dd;
      out_ready = ordy;
      #1;
      check_outputs(e_ir, e_ov);
      m_zero = 1'b0;
      if (e_ir && iv) begin
         if (dd == 8'd0) m_zero = 1'b1;
         else for (int i = 7; i >= 0; i--) if (dd[i]) q.push_back(i);
      end
      if (e_ov && ordy) void'(q.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bit e_ir;
      bit e_ov;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_zero = 1'b0;
      check_outputs(e_ir, e_ov);
      @(posedge clk);
      #1;
      check_outputs(e_ir, e_ov);
      rst_n = 1'b1;
   endtask

   initial begin
      enable = 1'b1;
      do_reset();

      // Four-bit vector drains 7,5,2,0 then returns to idle.
      cyc(1, 1, 8'hA5, 1);
      repeat (5) cyc(1, 0, 8'h00, 1);

      // One-hot sweep, first blocked by enable=0.
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 8'(1 << i), 1);
         cyc(1, 1, 8'(1 << i), 1);
         cyc(1, 0, 8'h00, 1);
      end
      cyc(1, 0, 8'h00, 1);

      // All-zero capture pulses zero only.
      cyc(1, 1, 8'h00, 1);
      repeat (2) cyc(1, 0, 8'h00, 1);

      // Backpressure holds the beat.
      cyc(1, 1, 8'h30, 0);
      repeat (3) cyc(1, 1, 8'hFF, 0);
      repeat (3) cyc(1, 0, 8'h00, 1);

      // Enable freeze mid-drain.
      cyc(1, 1, 8'hFF, 1);
      repeat (2) cyc(1, 0, 8'h00, 1);
      repeat (4) cyc(0, 0, 8'h00, 1);
      repeat (7) cyc(1, 0, 8'h00, 1);

      // Reset mid-drain discards everything.
      cyc(1, 1, 8'hC3, 1);
      cyc(1, 0, 8'h00, 1);
      do_reset();
      repeat (3) cyc(1, 0, 8'h00, 1);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 7) != 0,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                $urandom_range(0, 3) != 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
